alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand/result width.
REQ-002 The block SHALL have parameter OPW, default 3, meaning the ALU opcode width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk  in  1  the single clock, rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port req_valid  in  2  per-requester request valid; bit i belongs to requester i.
REQ-007 Port req_ready  out  2  per-requester accept; at most one bit set.
REQ-008 Ports req0_op/req1_op  in  OPW  requested opcode: 0 zero, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 nor, 7 zero.
REQ-009 Ports req0_a/req0_b/req1_a/req1_b  in  WIDTH  requester operands.
REQ-010 Port rsp_valid  out  2  one-hot response valid, to the owning requester.
REQ-011 Port rsp_ready  in  2  per-requester response accept.
REQ-012 Port rsp_data  out  WIDTH  result, qualified by rsp_valid.
REQ-013 Port rsp_bgtz  out  1  captured branch flag, qualified by rsp_valid.
REQ-014 Ports alu_op  out  OPW, alu_a/alu_b  out  WIDTH  drive the shared external ALU.
REQ-015 Ports alu_out  in  WIDTH, alu_bgtz  in  1  return from the shared ALU, combinational.
REQ-016 Port busy  out  1  high whenever state is not IDLE.
REQ-017 Port op_count  out  16  count of completed response handshakes.

Function
REQ-018 States SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-019 In IDLE with any req_valid set, req_ready SHALL be one-hot on the granted requester; else 0.
REQ-020 Grant: single valid wins; both valid -> requester not served last; last-served pointer resets to 1 (requester 0 wins first tie).
REQ-021 Accept = req_valid[i] & req_ready[i]; on accept, op/a/b of requester i and owner id SHALL be registered and state -> EXEC.
REQ-022 req_ready SHALL be 0 in EXEC and RESP; request inputs ignored there.
REQ-023 alu_a/alu_b SHALL always be driven from operand registers; alu_op SHALL be the registered op in EXEC, 0 otherwise.
REQ-024 EXEC lasts exactly one cycle: alu_out/alu_bgtz SHALL be captured into result registers at its end; state -> RESP.
REQ-025 In RESP, rsp_valid[owner] SHALL be 1; rsp_data/rsp_bgtz stable until rsp_ready[owner] is high.
REQ-026 rsp_ready of the non-owner SHALL be ignored.
REQ-027 On response handshake: state -> IDLE, last-served pointer <- owner, op_count increments, wrapping 0xFFFF -> 0x0000.
REQ-028 Latency SHALL be accept cycle N -> rsp_valid high at N+2; minimum 3 cycles per operation, no overlap.
REQ-029 Opcode 7 SHALL be forwarded unchanged; result is whatever the ALU returns.
REQ-030 Requester waiting in IDLE SHALL see ready within one cycle of IDLE re-entry (no starvation beyond one op).

Reset
REQ-031 rst_n low SHALL force: state IDLE, req_ready 0, rsp_valid 0, rsp_data 0, rsp_bgtz 0, operands 0, alu_op 0, busy 0, op_count 0, pointer 1.
REQ-032 Reset during EXEC or RESP SHALL drop the transaction with no response issued.

Structure
REQ-033 Opcode constants and state encoding SHALL live in the shared ALU package.
REQ-034 Round-robin grant logic SHALL be sub-module rr_arb2 (2 valids + pointer in, one-hot grant out).
REQ-035 The ALU SHALL NOT be instantiated inside; it is shared via alu_* ports.

Verification
REQ-036 Req0 add 5+7 alone -> req_ready=01 at N, rsp_valid=01 at N+2, rsp_data=12, op_count=1.
REQ-037 Both valid from reset, req0 sub 3-5, req1 xor F0^0F -> req0 first (0xFFFFFFFE), then req1 (0x000000FF).
REQ-038 Both held valid for 4 ops -> grants alternate 0,1,0,1; op_count=4.
REQ-039 rsp_ready held 0 for 5 cycles in RESP -> rsp_data stable, req_ready=00, busy=1 throughout.
REQ-040 rst_n low during EXEC -> no rsp_valid, all outputs at reset values, op_count unchanged at 0.
REQ-041 op_count preloaded by 65535 handshakes -> next handshake wraps op_count to 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: opcode encodings and the arbiter state encoding.
package alu_arbiter_pkg;

   localparam logic [2:0] OP_ZERO  = 3'd0;
   localparam logic [2:0] OP_ADD   = 3'd1;
   localparam logic [2:0] OP_SUB   = 3'd2;
   localparam logic [2:0] OP_AND   = 3'd3;
   localparam logic [2:0] OP_OR    = 3'd4;
   localparam logic [2:0] OP_XOR   = 3'd5;
   localparam logic [2:0] OP_NOR   = 3'd6;
   localparam logic [2:0] OP_ZERO7 = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester not served last.
module rr_arb2 (
   input  logic [1:0] valid_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = valid_i;
      if (valid_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared external ALU; one operation in
// flight at a time, result held until the owning requester accepts it.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [OPW-1:0]   req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_bgtz,
   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_bgtz,
   output logic             busy,
   output logic [15:0]      op_count
);

   state_e           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic [OPW-1:0]   op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             bgtz_q, bgtz_d;
   logic [15:0]      op_count_q, op_count_d;
   logic [1:0]       gnt;

   rr_arb2 u_arb (
      .valid_i (req_valid),
      .last_i  (last_q),
      .gnt_o   (gnt)
   );

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      bgtz_d     = bgtz_q;
      op_count_d = op_count_q;
      req_ready  = 2'b00;
      rsp_valid  = 2'b00;
      case (state_q)
         ST_IDLE: begin
            // Gate with reset so ready stays low while reset is held.
            req_ready = rst_n ? gnt : 2'b00;
            if (|req_ready) begin
               owner_d = gnt[1];
               op_d    = gnt[1] ? req1_op : req0_op;
               a_d     = gnt[1] ? req1_a  : req0_a;
               b_d     = gnt[1] ? req1_b  : req0_b;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_d   = alu_out;
            bgtz_d  = alu_bgtz;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid[owner_q] = 1'b1;
            if (rsp_ready[owner_q]) begin
               last_d     = owner_q;
               op_count_d = op_count_q + 16'd1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b0;
         last_q     <= 1'b1;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         bgtz_q     <= 1'b0;
         op_count_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         bgtz_q     <= bgtz_d;
         op_count_q <= op_count_d;
      end
   end

   assign alu_a    = a_q;
   assign alu_b    = b_q;
   assign alu_op   = (state_q == ST_EXEC) ? op_q : OPW'(OP_ZERO);
   assign rsp_data = res_q;
   assign rsp_bgtz = bgtz_q;
   assign busy     = (state_q != ST_IDLE);
   assign op_count = op_count_q;

endmodule
